alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RESET_LAST, default 1, SHALL be the reset value of the last-grant register (1 gives requester 0 the first tie).
REQ-002 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 reqNValid  in  1  (N=0,1) SHALL mark that requester N presents an operation.
REQ-005 reqNReady  out  1  (N=0,1) SHALL mark that requester N's operation is accepted this cycle.
REQ-006 reqNA, reqNB  in  32 each  (N=0,1) SHALL be signed operands input1/input2.
REQ-007 reqNOp  in  4  (N=0,1) SHALL be the ALU control code.
REQ-008 reqNShamt  in  5  (N=0,1) SHALL be the shift amount.
REQ-009 respNValid  out  1  (N=0,1) SHALL mark a valid result for requester N.
REQ-010 respNReady  in  1  (N=0,1) SHALL mark that requester N takes the result.
REQ-011 respResult  out  32  SHALL be the shared, registered signed result; it is qualified only by respNValid.
REQ-012 grantId  out  1  SHALL be the index of the requester owning the current operation.
REQ-013 busy  out  1  SHALL be high whenever state is not IDLE.

Function
REQ-014 The ALU function SHALL be selected by the op code as follows; add and sub wrap modulo 2^32 and there is no overflow flag.
- 0: A+B
- 1: A-B
- 2: A&B
- 3: A|B
- 4: A<<shamt
- 5: logical A>>shamt
- 6: arithmetic A>>>shamt
- 7: 1 if signed A>B, else 0
- 8: 1 if signed A<B, else 0
- 9-15: 0
REQ-015 The FSM SHALL have exactly three states, IDLE, EXEC and RESP; encoding is free.
REQ-016 In IDLE, grant selection SHALL be as follows:
- only one reqNValid high: grant that requester
- both high: grant the requester not equal to lastGrant
- none high: no grant
REQ-017 reqNReady SHALL be a combinational function of state, the valids and lastGrant, high only in IDLE for the granted requester; the two readys are never high together.
REQ-018 On a transfer (reqNValid && reqNReady), the block SHALL latch A, B, Op, Shamt and grantId, set lastGrant=N, and go to EXEC.
REQ-019 Request inputs outside IDLE SHALL be ignored, and operand changes after acceptance SHALL NOT affect the result.
REQ-020 A requester SHALL be allowed to drop reqNValid without a handshake; this has no side effect.
REQ-021 EXEC SHALL last exactly one cycle: it computes the latched operation into the result register and goes to RESP.
REQ-022 In RESP, the block SHALL:
- drive resp[grantId]Valid=1 and the other respValid=0
- hold respResult and grantId stable
- stay in RESP until resp[grantId]Ready=1, then go to IDLE
REQ-023 The response of a request accepted in cycle T SHALL be valid from cycle T+2; with respReady held high it completes in T+2, and the next acceptance is possible no earlier than T+3.
REQ-024 There SHALL be no bypass: no acceptance in the cycle RESP completes.
REQ-025 respReady of the non-granted requester, and any respReady outside RESP, SHALL be ignored.
REQ-026 respResult SHALL retain its last computed value while in IDLE.

Reset
REQ-027 Reset SHALL drive the following values, with the outputs taking them from the first cycle after reset is sampled:
- state=IDLE
- result register=0
- latched operands=0
- grantId=0
- lastGrant=RESET_LAST
- busy=0
- all reqNReady/respNValid=0
REQ-028 Reset asserted in EXEC or RESP SHALL discard the pending operation, and no respNValid SHALL follow reset.
REQ-029 When reset and a transfer coincide, reset SHALL win: nothing is latched.

Verification
REQ-030 A bench SHALL cover these directed scenarios:
- Reset, then only req0 with A=7, B=5, op=1, respReady0=1: req0Ready=1 in T; resp0Valid=1 and respResult=2 in T+2; busy=0 in T+3.
- Both valid after reset with RESET_LAST=1, then both re-request: grant order 0,1,0,1; ops 0 (3+4=7) and 6 (A=0x80000000, shamt=4 -> 0xF8000000).
- Stalled response: resp1Ready held 0 for 5 cycles: resp1Valid and respResult stable, busy=1, req0Ready=0 throughout; completes the cycle resp1Ready=1.
- Op coverage: op=5 with A=0x80000000, shamt=31 -> 1; op=7 with A=-1, B=0 -> 0; op=8 with A=-1, B=0 -> 1; op=12 -> 0; op=0 with A=0x7FFFFFFF, B=1 -> 0x80000000.
- Reset mid-EXEC and mid-RESP: resp valids never assert afterward, state IDLE, lastGrant=RESET_LAST; operand change after accept does not alter the result.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit ALU between two requesters.
//
// A round-robin arbiter picks one requester in IDLE. The accepted operation is
// latched, evaluated in EXEC, and its result is held in RESP until the owning
// requester takes it. Each operation occupies the block for three cycles.
//
// Ports
//   clock, reset              single clock, synchronous active-high reset
//   reqN{Valid,A,B,Op,Shamt}  request from requester N (N = 0, 1)
//   reqNReady                 request accepted this cycle (combinational)
//   respNValid / respNReady   result handshake for requester N
//   respResult                shared registered result, qualified by respNValid
//   grantId                   requester owning the current operation
//   busy                      high whenever the block is not idle
module alu_arbiter #(
    parameter logic RESET_LAST = 1'b1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req0Valid,
    output logic        req0Ready,
    input  logic [31:0] req0A,
    input  logic [31:0] req0B,
    input  logic [3:0]  req0Op,
    input  logic [4:0]  req0Shamt,

    input  logic        req1Valid,
    output logic        req1Ready,
    input  logic [31:0] req1A,
    input  logic [31:0] req1B,
    input  logic [3:0]  req1Op,
    input  logic [4:0]  req1Shamt,

    output logic        resp0Valid,
    input  logic        resp0Ready,
    output logic        resp1Valid,
    input  logic        resp1Ready,

    output logic [31:0] respResult,
    output logic        grantId,
    output logic        busy
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_SLL = 4'd4;
    localparam logic [OP_W-1:0] OP_SRL = 4'd5;
    localparam logic [OP_W-1:0] OP_SRA = 4'd6;
    localparam logic [OP_W-1:0] OP_SGT = 4'd7;
    localparam logic [OP_W-1:0] OP_SLT = 4'd8;

    // Operation payload as captured from a requester.
    typedef struct packed {
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [OP_W-1:0]    op;
        logic [SHAMT_W-1:0] shamt;
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    alu_op_t           op_q, op_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              resp0_valid_q, resp0_valid_d;
    logic              resp1_valid_q, resp1_valid_d;

    alu_op_t           req0_pl_c, req1_pl_c;
    logic              gnt_valid_c;
    logic              gnt_id_c;
    logic              resp_take_c;
    logic [DATA_W-1:0] alu_c;

    assign req0_pl_c = '{a: req0A, b: req0B, op: req0Op, shamt: req0Shamt};
    assign req1_pl_c = '{a: req1A, b: req1B, op: req1Op, shamt: req1Shamt};

    // Arbitration: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin : arbiter
        gnt_valid_c = 1'b0;
        gnt_id_c    = 1'b0;
        if (state_q == IDLE) begin
            if (req0Valid && req1Valid) begin
                gnt_valid_c = 1'b1;
                gnt_id_c    = ~last_q;
            end else if (req0Valid) begin
                gnt_valid_c = 1'b1;
                gnt_id_c    = 1'b0;
            end else if (req1Valid) begin
                gnt_valid_c = 1'b1;
                gnt_id_c    = 1'b1;
            end
        end
    end

    // A grant is only offered while a request is present, so grant == transfer.
    assign req0Ready = gnt_valid_c & ~gnt_id_c;
    assign req1Ready = gnt_valid_c &  gnt_id_c;

    // Only the owner's respReady can retire the result.
    assign resp_take_c = grant_q ? resp1Ready : resp0Ready;

    // ALU on the latched operation; add/sub wrap, no overflow reporting.
    always_comb begin : alu
        alu_c = '0;
        case (op_q.op)
            OP_ADD:  alu_c = op_q.a + op_q.b;
            OP_SUB:  alu_c = op_q.a - op_q.b;
            OP_AND:  alu_c = op_q.a & op_q.b;
            OP_OR:   alu_c = op_q.a | op_q.b;
            OP_SLL:  alu_c = op_q.a << op_q.shamt;
            OP_SRL:  alu_c = op_q.a >> op_q.shamt;
            OP_SRA:  alu_c = DATA_W'($signed(op_q.a) >>> op_q.shamt);
            OP_SGT:  alu_c = ($signed(op_q.a) > $signed(op_q.b)) ? DATA_W'(1) : '0;
            OP_SLT:  alu_c = ($signed(op_q.a) < $signed(op_q.b)) ? DATA_W'(1) : '0;
            default: alu_c = '0;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin : fsm_next
        state_d  = state_q;
        op_d     = op_q;
        result_d = result_q;
        grant_d  = grant_q;
        last_d   = last_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid_c) begin
                    op_d    = gnt_id_c ? req1_pl_c : req0_pl_c;
                    grant_d = gnt_id_c;
                    last_d  = gnt_id_c;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_c;
                state_d  = RESP;
            end
            RESP: begin
                // Return to IDLE only; no same-cycle acceptance.
                if (resp_take_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d        = (state_d != IDLE);
        resp0_valid_d = (state_d == RESP) && !grant_d;
        resp1_valid_d = (state_d == RESP) &&  grant_d;
    end

    // State register; reset discards any pending operation.
    always_ff @(posedge clock) begin : fsm_regs
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= '0;
            result_q      <= '0;
            grant_q       <= 1'b0;
            last_q        <= RESET_LAST;
            busy_q        <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            result_q      <= result_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            busy_q        <= busy_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
        end
    end

    assign respResult = result_q;
    assign grantId    = grant_q;
    assign busy       = busy_q;
    assign resp0Valid = resp0_valid_q;
    assign resp1Valid = resp1_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter.
// A reference model predicts grants and results at transaction level; a
// separate monitor retires expected responses as the DUT presents them.
module tb_alu_arbiter;

    localparam logic RESET_LAST = 1'b1;

    logic        clock;
    logic        reset;
    logic        req0Valid, req0Ready, req1Valid, req1Ready;
    logic [31:0] req0A, req0B, req1A, req1B;
    logic [3:0]  req0Op, req1Op;
    logic [4:0]  req0Shamt, req1Shamt;
    logic        resp0Valid, resp0Ready, resp1Valid, resp1Ready;
    logic [31:0] respResult;
    logic        grantId;
    logic        busy;

    alu_arbiter #(.RESET_LAST(RESET_LAST)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0Valid  (req0Valid),
        .req0Ready  (req0Ready),
        .req0A      (req0A),
        .req0B      (req0B),
        .req0Op     (req0Op),
        .req0Shamt  (req0Shamt),
        .req1Valid  (req1Valid),
        .req1Ready  (req1Ready),
        .req1A      (req1A),
        .req1B      (req1B),
        .req1Op     (req1Op),
        .req1Shamt  (req1Shamt),
        .resp0Valid (resp0Valid),
        .resp0Ready (resp0Ready),
        .resp1Valid (resp1Valid),
        .resp1Ready (resp1Ready),
        .respResult (respResult),
        .grantId    (grantId),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic [31:0] res;
        longint      due;
    } exp_t;

    exp_t        sb_q[$];
    int          acc_log[$];
    logic [31:0] done_log[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    longint      cyc      = 0;
    logic        rst_seen = 1'b1;
    int          acc_cnt[2];
    int          done_cnt = 0;
    longint      done_cyc = -1;
    logic [31:0] hold_exp = '0;
    logic [31:0] done_dut_result = '0;
    int          m_last = int'(RESET_LAST);
    bit          front_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Reference ALU written directly from the operation table.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, input logic [4:0] sh);
        int sa;
        int sbv;
        sa  = a;
        sbv = b;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a << sh;
            4'd5:    return a >> sh;
            4'd6:    return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'd7:    return (sa > sbv) ? 32'd1 : 32'd0;
            4'd8:    return (sa < sbv) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clock) begin
        cyc      = cyc + 1;
        rst_seen = reset;
    end

    task automatic model_accept(input int n, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] op, input logic [4:0] sh);
        sb_q.push_back('{id: n, res: ref_alu(a, b, op, sh), due: cyc + 2});
        m_last = n;
        acc_cnt[n]++;
        acc_log.push_back(n);
    endtask

    // Reference model: arbitration, acceptance and idle/busy expectations.
    always @(negedge clock) begin
        logic e0;
        logic e1;
        if (reset) begin
            sb_q.delete();
            m_last     = int'(RESET_LAST);
            hold_exp   = '0;
            front_seen = 1'b0;
            done_cyc   = -1;
        end else begin
            if (rst_seen) begin
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_resp_valid", 32'({resp1Valid, resp0Valid}), 32'd0);
                check("rst_grant", 32'(grantId), 32'd0);
                check("rst_result", respResult, 32'd0);
            end
            if (sb_q.size() == 0 && done_cyc != cyc) begin
                e0 = req0Valid && (!req1Valid || m_last == 1);
                e1 = req1Valid && (!req0Valid || m_last == 0);
                check("req_ready", 32'({req1Ready, req0Ready}), 32'({e1, e0}));
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_result_hold", respResult, hold_exp);
                if (e0) model_accept(0, req0A, req0B, req0Op, req0Shamt);
                else if (e1) model_accept(1, req1A, req1B, req1Op, req1Shamt);
            end else begin
                check("busy_ready", 32'({req1Ready, req0Ready}), 32'd0);
                check("busy_flag", 32'(busy), 32'd1);
            end
        end
    end

    // Monitor: compares every presented response against the scoreboard head.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (resp0Valid || resp1Valid) begin
                if (sb_q.size() == 0) begin
                    fail_now("spurious_resp");
                end else begin
                    e = sb_q[0];
                    check("resp_valid_pair", 32'({resp1Valid, resp0Valid}), (e.id == 1) ? 32'd2 : 32'd1);
                    check("resp_grant_id", 32'(grantId), 32'(e.id));
                    check("resp_result", respResult, e.res);
                    if (!front_seen) begin
                        check("resp_latency", 32'(cyc), 32'(e.due));
                        front_seen = 1'b1;
                    end
                    if ((e.id == 0 && resp0Ready) || (e.id == 1 && resp1Ready)) begin
                        void'(sb_q.pop_front());
                        hold_exp        = e.res;
                        done_dut_result = respResult;
                        done_log.push_back(respResult);
                        done_cyc        = cyc;
                        front_seen      = 1'b0;
                        done_cnt++;
                    end
                end
            end else if (sb_q.size() != 0 && cyc >= sb_q[0].due) begin
                fail_now("resp_missing");
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [4:0] sh);
        if (n == 0) begin
            req0A = a; req0B = b; req0Op = op; req0Shamt = sh;
        end else begin
            req1A = a; req1B = b; req1Op = op; req1Shamt = sh;
        end
    endtask

    task automatic set_valid(input int n, input logic v);
        if (n == 0) req0Valid = v;
        else        req1Valid = v;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom % 6)
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'hFFFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic rand_req(input int n);
        set_req(n, pick_operand(), pick_operand(), 4'($urandom % 16), 5'($urandom % 32));
    endtask

    task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [4:0] sh);
        int start;
        start = acc_cnt[n];
        set_req(n, a, b, op, sh);
        set_valid(n, 1'b1);
        for (int i = 0; i < 50 && acc_cnt[n] == start; i++) tick();
        set_valid(n, 1'b0);
        if (acc_cnt[n] == start) fail_now("accept_timeout");
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 60 && done_cnt < target; i++) tick();
        if (done_cnt < target) fail_now("done_timeout");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [31:0] t_a[5];
    logic [31:0] t_b[5];
    logic [3:0]  t_op[5];
    logic [4:0]  t_sh[5];
    logic [31:0] t_exp[5];

    initial begin
        int d;
        int base;
        int dbase;
        int a0;
        int seen_acc[2];

        reset      = 1'b1;
        req0Valid  = 1'b0;
        req1Valid  = 1'b0;
        set_req(0, 32'd0, 32'd0, 4'd0, 5'd0);
        set_req(1, 32'd0, 32'd0, 4'd0, 5'd0);
        resp0Ready = 1'b0;
        resp1Ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Single request: 7 - 5.
        resp0Ready = 1'b1;
        resp1Ready = 1'b1;
        d = done_cnt;
        issue(0, 32'd7, 32'd5, 4'd1, 5'd0);
        wait_done(d + 1);
        check("d1_result", done_dut_result, 32'd2);
        check("d1_busy_after", 32'(busy), 32'd0);

        // Contention from reset: grants alternate 0,1,0,1.
        do_reset();
        set_req(0, 32'd3, 32'd4, 4'd0, 5'd0);
        set_req(1, 32'h8000_0000, 32'd0, 4'd6, 5'd4);
        base  = acc_log.size();
        dbase = done_log.size();
        d     = done_cnt;
        req0Valid = 1'b1;
        req1Valid = 1'b1;
        for (int i = 0; i < 80 && acc_log.size() < base + 4; i++) tick();
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        wait_done(d + 4);
        if (acc_log.size() < base + 4 || done_log.size() < dbase + 4) begin
            fail_now("d2_too_few_transactions");
        end else begin
            for (int i = 0; i < 4; i++) begin
                check("d2_grant_order", 32'(acc_log[base + i]), 32'(i % 2));
                check("d2_result", done_log[dbase + i], (i % 2 == 1) ? 32'hF800_0000 : 32'd7);
            end
        end

        // Stalled response to requester 1 while requester 0 waits.
        resp0Ready = 1'b1;
        resp1Ready = 1'b0;
        set_req(0, 32'd11, 32'd22, 4'd0, 5'd0);
        d = done_cnt;
        issue(1, 32'h1234_5678, 32'h0F0F_0F0F, 4'd2, 5'd0);
        req0Valid = 1'b1;
        repeat (6) tick();
        check("d3_stall_valid", 32'(resp1Valid), 32'd1);
        check("d3_stall_busy", 32'(busy), 32'd1);
        check("d3_stall_req0_ready", 32'(req0Ready), 32'd0);
        check("d3_stall_not_done", 32'(done_cnt), 32'(d));
        resp1Ready = 1'b1;
        a0 = acc_cnt[0];
        for (int i = 0; i < 20 && acc_cnt[0] == a0; i++) tick();
        req0Valid = 1'b0;
        if (acc_cnt[0] == a0) fail_now("d3_req0_accept_timeout");
        wait_done(d + 2);
        if (done_log.size() >= 2) check("d3_result1", done_log[done_log.size() - 2], 32'h0204_0608);
        else fail_now("d3_result1_missing");
        check("d3_result0", done_dut_result, 32'd33);

        // Operation corner cases.
        t_a   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h7FFF_FFFF};
        t_b   = '{32'd0, 32'd0, 32'd0, 32'd6, 32'd1};
        t_op  = '{4'd5, 4'd7, 4'd8, 4'd12, 4'd0};
        t_sh  = '{5'd31, 5'd0, 5'd0, 5'd0, 5'd0};
        t_exp = '{32'd1, 32'd0, 32'd1, 32'd0, 32'h8000_0000};
        resp0Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = done_cnt;
            issue(0, t_a[i], t_b[i], t_op[i], t_sh[i]);
            wait_done(d + 1);
            check("d4_op_result", done_dut_result, t_exp[i]);
        end

        // Operands changing after acceptance must not matter.
        d = done_cnt;
        issue(0, 32'd10, 32'd20, 4'd0, 5'd0);
        req0A = 32'd999;
        req0B = 32'd1;
        wait_done(d + 1);
        check("d5_operand_change", done_dut_result, 32'd30);

        // Reset while in EXEC.
        d = done_cnt;
        issue(0, 32'd1, 32'd2, 4'd0, 5'd0);
        reset = 1'b1;
        req0A = 32'd5;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("d5_exec_rst_valid", 32'({resp1Valid, resp0Valid}), 32'd0);
        check("d5_exec_rst_busy", 32'(busy), 32'd0);
        check("d5_exec_rst_no_done", 32'(done_cnt), 32'(d));

        // Reset while in RESP.
        resp0Ready = 1'b0;
        d = done_cnt;
        issue(0, 32'd3, 32'd3, 4'd0, 5'd0);
        tick();
        check("d5_in_resp", 32'(resp0Valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("d5_resp_rst_valid", 32'({resp1Valid, resp0Valid}), 32'd0);
        check("d5_resp_rst_busy", 32'(busy), 32'd0);
        check("d5_resp_rst_no_done", 32'(done_cnt), 32'(d));

        // lastGrant is back at its reset value: a tie goes to requester 0.
        resp0Ready = 1'b1;
        resp1Ready = 1'b1;
        base = acc_log.size();
        d    = done_cnt;
        req0Valid = 1'b1;
        req1Valid = 1'b1;
        for (int i = 0; i < 20 && acc_log.size() == base; i++) tick();
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        if (acc_log.size() > base) check("d5_last_grant", 32'(acc_log[base]), 32'd0);
        else fail_now("d5_last_grant_timeout");
        wait_done(d + 1);

        // Randomized traffic with occasional resets.
        seen_acc[0] = acc_cnt[0];
        seen_acc[1] = acc_cnt[1];
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (acc_cnt[n] != seen_acc[n]) begin
                    seen_acc[n] = acc_cnt[n];
                    rand_req(n);
                    set_valid(n, 1'(($urandom % 4) != 0));
                end else begin
                    if (($urandom % 8) == 0) set_valid(n, (n == 0) ? !req0Valid : !req1Valid);
                    if (($urandom % 4) == 0) rand_req(n);
                end
            end
            resp0Ready = 1'(($urandom % 10) < 6);
            resp1Ready = 1'(($urandom % 10) < 6);
            reset      = 1'(($urandom % 400) == 0);
            tick();
        end

        // Drain outstanding work.
        reset      = 1'b0;
        req0Valid  = 1'b0;
        req1Valid  = 1'b0;
        resp0Ready = 1'b1;
        resp1Ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
